alu_multicycle: RTL and testbench

//  Parametrised execute-stage ALU with valid/ready handshakes on input and output.

---
 rtl/alu_multicycle_if.sv | 46 ++++
 rtl/alu_multicycle.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// -----------------------------------------------------------------------------
// alu_multicycle_if
//   Handshake/bus bundle between the ID/EX operand latch (master) and the
//   execute-stage ALU (slave).
//
//   Input side  : in_valid/in_ready handshake carrying op, data1, data2, shamt.
//                 A transfer happens on a rising edge where both are high.
//   Output side : out_valid/out_ready handshake carrying result, result_hi,
//                 overflow, zero, illegal. The consumer takes the result on a
//                 rising edge where both are high.
//
//   Modports
//     master : the producer of operations and the consumer of results
//     slave  : the ALU
// -----------------------------------------------------------------------------
interface alu_multicycle_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  // Operation side
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         op;
  logic [WIDTH-1:0]   data1;
  logic [WIDTH-1:0]   data2;
  logic [SHAMT_W-1:0] shamt;

  // Result side
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_hi;
  logic               overflow;
  logic               zero;
  logic               illegal;

  modport master (
    output in_valid, op, data1, data2, shamt, out_ready,
    input  in_ready, out_valid, result, result_hi, overflow, zero, illegal
  );

  modport slave (
    input  in_valid, op, data1, data2, shamt, out_ready,
    output in_ready, out_valid, result, result_hi, overflow, zero, illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   Execute-stage ALU with valid/ready handshakes on both sides.
//
//   Single-cycle ops (ADD, SUB, AND, OR, SLL, SRL, SRA, SGT, SLT, NOR) and
//   illegal opcodes are computed combinationally from the bus inputs and
//   loaded into the result registers on the accepting edge, so the result is
//   visible right after that edge.
//
//   MULT/MULTU run a shift-add multiplier over the operand magnitudes, one
//   partial-product step per cycle. A signed product is formed by negating
//   the unsigned product when the operand signs differ. The product is loaded
//   WIDTH+1 edges after the accepting edge.
//
//   Ports
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous, active-high reset
//     bus  : alu_multicycle_if.slave (operation and result handshakes)
//
//   Opcodes
//     0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 SGT, 8 SLT, 9 NOR,
//     10 MULT, 11 MULTU, 12..15 illegal (10/11 also illegal when MUL_EN=0)
// -----------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int MUL_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_multicycle_if.slave    bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SRA   = 4'd6;
  localparam logic [3:0] OP_SGT   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;

  // The counter runs 0..WIDTH: WIDTH steps, then one edge to load the product.
  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W + 1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,   // empty, ready for any op
    S_MUL,    // multiplier iterating
    S_HOLD    // result registers valid, waiting for out_ready
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,     state_d;
  logic [SHAMT_W:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   mcand_q,     mcand_d;      // multiplicand magnitude
  logic [2*WIDTH-1:0] prod_q,      prod_d;       // {partial sum, multiplier}
  logic               neg_q,       neg_d;        // product must be negated
  logic               mul_zero_q,  mul_zero_d;   // zero flag of the pending MULT

  logic [WIDTH-1:0]   result_q,    result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               overflow_q,  overflow_d;
  logic               zero_q,      zero_d;
  logic               illegal_q,   illegal_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic in_ready;
  logic accept;

  // In HOLD a new op may only enter on the same edge the old result retires.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated from the bus inputs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_result;
  logic             sc_overflow;
  logic             sc_illegal;
  logic             is_mul;

  assign a    = bus.data1;
  assign b    = bus.data2;
  assign sum  = a + b;
  assign diff = a - b;

  // NOTE: every signal written in an always_comb block gets a default on its
  // first lines, so no path through the case statements can leave it unassigned
  // and infer a latch.
  always_comb begin
    sc_result   = '0;
    sc_overflow = 1'b0;
    sc_illegal  = 1'b0;
    is_mul      = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_result   = sum;
        sc_overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_result   = diff;
        sc_overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_NOR:  sc_result = ~(a | b);
      OP_SLL:  sc_result = a << bus.shamt;
      OP_SRL:  sc_result = a >> bus.shamt;
      OP_SRA:  sc_result = $signed(a) >>> bus.shamt;
      OP_SGT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MULT, OP_MULTU: begin
        if (MUL_EN != 0) is_mul = 1'b1;
        else             sc_illegal = 1'b1;
      end
      default: sc_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier datapath
  // ---------------------------------------------------------------------------
  logic             mul_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   partial;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_final;

  // Magnitudes of the operands. The most negative value maps onto itself,
  // which is its correct unsigned magnitude.
  assign mul_signed = (bus.op == OP_MULT);
  assign a_mag      = (mul_signed && a[MSB]) ? -a : a;
  assign b_mag      = (mul_signed && b[MSB]) ? -b : b;

  // Add the multiplicand into the upper half when the current multiplier bit
  // is set, then shift the whole register right. The extra carry bit of
  // `partial` becomes the new MSB, so nothing is lost.
  assign partial    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_step  = {partial, prod_q[WIDTH-1:1]};
  assign prod_final = neg_q ? -prod_q : prod_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    neg_d       = neg_q;
    mul_zero_d  = mul_zero_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;

    case (state_q)
      S_IDLE: ;  // waits for an accept, handled below
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          result_d    = prod_final[WIDTH-1:0];
          result_hi_d = prod_final[2*WIDTH-1:WIDTH];
          overflow_d  = 1'b0;
          zero_d      = mul_zero_q;
          illegal_d   = 1'b0;
          state_d     = S_HOLD;
        end else begin
          prod_d = prod_step;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An accept overrides the plain transitions above: it can only happen in
    // IDLE, or in HOLD on the edge the old result retires.
    if (accept) begin
      if (is_mul) begin
        mcand_d    = a_mag;
        prod_d     = {{WIDTH{1'b0}}, b_mag};
        neg_d      = mul_signed && (a[MSB] ^ b[MSB]);
        mul_zero_d = (a == b);
        cnt_d      = '0;
        state_d    = S_MUL;
      end else begin
        result_d    = sc_result;
        result_hi_d = '0;
        overflow_d  = sc_overflow;
        zero_d      = (a == b);
        illegal_d   = sc_illegal;
        state_d     = S_HOLD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of the
  // order in which the simulator evaluates the blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      neg_q       <= 1'b0;
      mul_zero_q  <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      neg_q       <= neg_d;
      mul_zero_q  <= mul_zero_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle (WIDTH=32). Expected values come
//   from a behavioural model that uses 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SRA   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_multicycle_if #(.WIDTH(W), .SHAMT_W(5)) bus ();

  alu_multicycle #(.WIDTH(W), .SHAMT_W(5), .MUL_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got running, want done)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: results straight from the arithmetic definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] lo, output logic [31:0] hi,
                       output logic ovf, output logic ill, output logic zr);
    longint      sa, sb, t;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lo  = '0;
    hi  = '0;
    ovf = 1'b0;
    ill = 1'b0;
    zr  = (a == b);
    case (op)
      4'd0: begin t = sa + sb; lo = t[31:0]; ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd1: begin t = sa - sb; lo = t[31:0]; ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = a << sh;
      4'd5: lo = a >> sh;
      4'd6: begin t = sa >>> sh; lo = t[31:0]; end
      4'd7: lo = (sa > sb) ? 32'd1 : 32'd0;
      4'd8: lo = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: lo = ~(a | b);
      4'd10: begin p = sa * sb; {hi, lo} = p; end
      4'd11: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; end
      default: ill = 1'b1;
    endcase
  endtask

  // Present one op with out_ready=1, wait for its result and check it all.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] elo, ehi;
    logic        eovf, eill, ezr;
    int          waited, lat;
    model(op, a, b, sh, elo, ehi, eovf, eill, ezr);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.data1     = a;
    bus.data2     = b;
    bus.shamt     = sh;
    bus.out_ready = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "/accept_timeout"}, 64'(waited >= 100), 64'd0);
    @(posedge clk);
    #1;
    // Scramble inputs: they must be ignored after the accept.
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.data1    = $urandom;
    bus.data2    = $urandom;
    bus.shamt    = 5'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/latency"},   64'(lat), (op == OP_MULT || op == OP_MULTU) ? 64'd33 : 64'd0);
    check({tag, "/result"},    64'(bus.result),    64'(elo));
    check({tag, "/result_hi"}, 64'(bus.result_hi), 64'(ehi));
    check({tag, "/overflow"},  64'(bus.overflow),  64'(eovf));
    check({tag, "/zero"},      64'(bus.zero),      64'(ezr));
    check({tag, "/illegal"},   64'(bus.illegal),   64'(eill));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] elo, ehi, x_lo;
    logic        eovf, eill, ezr;
    logic [31:0] b2b_exp [$];
    int          spurious;

    n_checks      = 0;
    n_errors      = 0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/out_valid", 64'(bus.out_valid), 64'd0);
    check("reset/in_ready",  64'(bus.in_ready),  64'd1);
    check("reset/result",    64'(bus.result),    64'd0);
    check("reset/flags",     64'({bus.overflow, bus.zero, bus.illegal}), 64'd0);
    rst = 1'b0;

    // Directed corner cases
    run_op("add_ovf",   OP_ADD,   32'h7FFF_FFFF, 32'h1,          5'd0);
    run_op("sub_ovf",   OP_SUB,   32'h8000_0000, 32'h1,          5'd0);
    run_op("sub_zero",  OP_SUB,   32'd5,         32'd5,          5'd0);
    run_op("sra",       OP_SRA,   32'hF000_0000, 32'h1234,       5'd4);
    run_op("srl",       OP_SRL,   32'hF000_0000, 32'h1234,       5'd4);
    run_op("sra_sh0",   OP_SRA,   32'h8000_0001, 32'h0,          5'd0);
    run_op("slt",       OP_SLT,   32'hFFFF_FFFF, 32'h1,          5'd0);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,          5'd0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd0);
    run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000,  5'd0);
    run_op("illegal",   4'd13,    32'h1,         32'h1,          5'd3);

    // Back-to-back ADDs: one result per clock
    idle_cycle();
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = OP_ADD;
      bus.data1    = $urandom;
      bus.data2    = $urandom;
      model(OP_ADD, bus.data1, bus.data2, 5'd0, elo, ehi, eovf, eill, ezr);
      b2b_exp.push_back(elo);
      @(posedge clk);
      #1;
      check("b2b/out_valid", 64'(bus.out_valid), 64'd1);
      check("b2b/result",    64'(bus.result),    64'(b2b_exp.pop_front()));
    end
    bus.in_valid = 1'b0;

    // Stall: out_ready low holds the result and blocks new ops
    idle_cycle();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.data1     = 32'd100;
    bus.data2     = 32'd23;
    model(OP_ADD, 32'd100, 32'd23, 5'd0, x_lo, ehi, eovf, eill, ezr);
    @(posedge clk);
    #1;
    check("hold/first", 64'(bus.result), 64'(x_lo));
    bus.data1 = 32'd7;
    bus.data2 = 32'd8;
    model(OP_ADD, 32'd7, 32'd8, 5'd0, elo, ehi, eovf, eill, ezr);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold/in_ready",  64'(bus.in_ready),  64'd0);
      check("hold/out_valid", 64'(bus.out_valid), 64'd1);
      check("hold/result",    64'(bus.result),    64'(x_lo));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("hold/next", 64'(bus.result), 64'(elo));

    // Reset in the middle of a multiply
    idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.data1    = 32'd1234;
    bus.data2    = 32'd5678;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mul/out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mul/in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_mul/outputs",   {bus.result, bus.result_hi}, 64'd0);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) spurious++;
    end
    check("rst_mul/spurious", 64'(spurious), 64'd0);
    run_op("after_rst", OP_ADD, 32'd40, 32'd2, 5'd0);

    // Randomised ops against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      run_op("rand", 4'($urandom_range(0, 15)), ra, rb, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
